// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter -- writeback arbiter feeding two common-data-bus broadcast slots.
//
// Three functional units (ALU=0, BR=1, LSU=2) present completed results. Each
// cycle up to two of them are granted (combinational ready) in round-robin
// priority order starting at rr_ptr. On the next rising edge the first grant
// lands in cdb0 and the second in cdb1. When all three request, the one left
// out becomes the head of the priority order for the following cycle.
//
// Ports
//   clk                         clock, rising edge
//   reset                       asynchronous, active-low reset
//   {alu,br,lsu}_valid_in       result request
//   {alu,br,lsu}_prd_in [6:0]   destination physical register
//   {alu,br,lsu}_rob_in [4:0]   ROB index of completing instruction
//   {alu,br,lsu}_ready_out      grant (transfer when valid && ready)
//   mispredict                  flush strobe: blocks all grants this cycle
//   cdb{0,1}_valid              broadcast slot valid (registered)
//   cdb{0,1}_preg [6:0]         broadcast physical-register tag (registered)
//   cdb{0,1}_rob  [4:0]         broadcast ROB tag (registered)
//   conflict_cnt [15:0]         3-way conflict counter
//
// Build option
//   WB_ARBITER_PERF_EN  when defined, conflict_cnt counts (saturating) the
//                       non-mispredict cycles with all three requests high;
//                       when undefined it is tied to zero and has no flops.
// -----------------------------------------------------------------------------
module wb_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        alu_valid_in,
  input  logic [6:0]  alu_prd_in,
  input  logic [4:0]  alu_rob_in,
  output logic        alu_ready_out,

  input  logic        br_valid_in,
  input  logic [6:0]  br_prd_in,
  input  logic [4:0]  br_rob_in,
  output logic        br_ready_out,

  input  logic        lsu_valid_in,
  input  logic [6:0]  lsu_prd_in,
  input  logic [4:0]  lsu_rob_in,
  output logic        lsu_ready_out,

  input  logic        mispredict,

  output logic        cdb0_valid,
  output logic [6:0]  cdb0_preg,
  output logic [4:0]  cdb0_rob,

  output logic        cdb1_valid,
  output logic [6:0]  cdb1_preg,
  output logic [4:0]  cdb1_rob,

  output logic [15:0] conflict_cnt
);

  localparam int N_REQ = 3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0] rr_ptr_q,     rr_ptr_d;
  logic       cdb0_valid_q, cdb0_valid_d;
  logic [6:0] cdb0_preg_q,  cdb0_preg_d;
  logic [4:0] cdb0_rob_q,   cdb0_rob_d;
  logic       cdb1_valid_q, cdb1_valid_d;
  logic [6:0] cdb1_preg_q,  cdb1_preg_d;
  logic [4:0] cdb1_rob_q,   cdb1_rob_d;

  // ---------------------------------------------------------------------------
  // Request view
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] req_valid;
  logic             all_req;

  assign req_valid = {lsu_valid_in, br_valid_in, alu_valid_in};
  assign all_req   = &req_valid;

  // rr_ptr == 3 can only arise from an upset; arbitrate as if it were 0.
  logic [1:0] rr_eff;
  assign rr_eff = (rr_ptr_q == 2'd3) ? 2'd0 : rr_ptr_q;

  // prio_idx[k] is the requester at priority position k (0 = highest).
  logic [1:0]       prio_idx [N_REQ];
  logic [N_REQ-1:0] prio_valid;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_prio
    logic [2:0] sum;
    assign sum            = {1'b0, rr_eff} + 3'(gi);
    assign prio_idx[gi]   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    assign prio_valid[gi] = req_valid[prio_idx[gi]];
  end

  // ---------------------------------------------------------------------------
  // Pick the first two valid requesters in priority order.
  // No grant at all while flushing or while reset is held.
  // ---------------------------------------------------------------------------
  logic       first_ok, second_ok;
  logic [1:0] first_sel, second_sel;

  always_comb begin
    first_ok   = 1'b0;
    second_ok  = 1'b0;
    first_sel  = 2'd0;
    second_sel = 2'd0;
    if (reset && !mispredict) begin
      if (prio_valid[0]) begin
        first_ok  = 1'b1;
        first_sel = prio_idx[0];
        if (prio_valid[1]) begin
          second_ok  = 1'b1;
          second_sel = prio_idx[1];
        end else if (prio_valid[2]) begin
          second_ok  = 1'b1;
          second_sel = prio_idx[2];
        end
      end else if (prio_valid[1]) begin
        first_ok  = 1'b1;
        first_sel = prio_idx[1];
        if (prio_valid[2]) begin
          second_ok  = 1'b1;
          second_sel = prio_idx[2];
        end
      end else if (prio_valid[2]) begin
        first_ok  = 1'b1;
        first_sel = prio_idx[2];
      end
    end
  end

  logic [N_REQ-1:0] grant;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
    assign grant[gi] = (first_ok  && (first_sel  == 2'(gi))) ||
                       (second_ok && (second_sel == 2'(gi)));
  end

  assign alu_ready_out = grant[0];
  assign br_ready_out  = grant[1];
  assign lsu_ready_out = grant[2];

  // ---------------------------------------------------------------------------
  // Payload selection for the two broadcast slots
  // ---------------------------------------------------------------------------
  logic [6:0] first_prd,  second_prd;
  logic [4:0] first_rob,  second_rob;

  always_comb begin
    first_prd = alu_prd_in;
    first_rob = alu_rob_in;
    case (first_sel)
      2'd1:    begin first_prd = br_prd_in;  first_rob = br_rob_in;  end
      2'd2:    begin first_prd = lsu_prd_in; first_rob = lsu_rob_in; end
      default: begin first_prd = alu_prd_in; first_rob = alu_rob_in; end
    endcase
  end

  always_comb begin
    second_prd = alu_prd_in;
    second_rob = alu_rob_in;
    case (second_sel)
      2'd1:    begin second_prd = br_prd_in;  second_rob = br_rob_in;  end
      2'd2:    begin second_prd = lsu_prd_in; second_rob = lsu_rob_in; end
      default: begin second_prd = alu_prd_in; second_rob = alu_rob_in; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // An empty slot broadcasts valid=0 but keeps its last tags.
    cdb0_valid_d = first_ok;
    cdb0_preg_d  = first_ok ? first_prd : cdb0_preg_q;
    cdb0_rob_d   = first_ok ? first_rob : cdb0_rob_q;
    cdb1_valid_d = second_ok;
    cdb1_preg_d  = second_ok ? second_prd : cdb1_preg_q;
    cdb1_rob_d   = second_ok ? second_rob : cdb1_rob_q;

    // Only a full 3-way conflict rotates the pointer: the requester left out
    // (last in the order) goes to the front. rr_eff also scrubs an illegal 3.
    rr_ptr_d = rr_eff;
    if (!mispredict && all_req) begin
      rr_ptr_d = prio_idx[2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= 2'd0;
      cdb0_valid_q <= 1'b0;
      cdb0_preg_q  <= 7'd0;
      cdb0_rob_q   <= 5'd0;
      cdb1_valid_q <= 1'b0;
      cdb1_preg_q  <= 7'd0;
      cdb1_rob_q   <= 5'd0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cdb0_valid_q <= cdb0_valid_d;
      cdb0_preg_q  <= cdb0_preg_d;
      cdb0_rob_q   <= cdb0_rob_d;
      cdb1_valid_q <= cdb1_valid_d;
      cdb1_preg_q  <= cdb1_preg_d;
      cdb1_rob_q   <= cdb1_rob_d;
    end
  end

  assign cdb0_valid = cdb0_valid_q;
  assign cdb0_preg  = cdb0_preg_q;
  assign cdb0_rob   = cdb0_rob_q;
  assign cdb1_valid = cdb1_valid_q;
  assign cdb1_preg  = cdb1_preg_q;
  assign cdb1_rob   = cdb1_rob_q;

  // ---------------------------------------------------------------------------
  // 3-way conflict counter (optional)
  // ---------------------------------------------------------------------------
`ifdef WB_ARBITER_PERF_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (!mispredict && all_req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter -- self-checking bench for wb_arbiter.
//
// The driver applies one request pattern per cycle (directed, then random),
// checks the combinational grants immediately and pushes the expected
// broadcast for the next edge into a queue; a monitor pops one entry after
// every rising edge and compares the registered outputs. The reference model
// keeps the round-robin head as a plain integer and walks the priority list
// with modulo arithmetic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_arbiter;

`ifdef WB_ARBITER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid_in, br_valid_in, lsu_valid_in;
  logic [6:0]  alu_prd_in, br_prd_in, lsu_prd_in;
  logic [4:0]  alu_rob_in, br_rob_in, lsu_rob_in;
  logic        alu_ready_out, br_ready_out, lsu_ready_out;
  logic        mispredict;
  logic        cdb0_valid, cdb1_valid;
  logic [6:0]  cdb0_preg, cdb1_preg;
  logic [4:0]  cdb0_rob, cdb1_rob;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid_in (alu_valid_in),
    .alu_prd_in   (alu_prd_in),
    .alu_rob_in   (alu_rob_in),
    .alu_ready_out(alu_ready_out),
    .br_valid_in  (br_valid_in),
    .br_prd_in    (br_prd_in),
    .br_rob_in    (br_rob_in),
    .br_ready_out (br_ready_out),
    .lsu_valid_in (lsu_valid_in),
    .lsu_prd_in   (lsu_prd_in),
    .lsu_rob_in   (lsu_rob_in),
    .lsu_ready_out(lsu_ready_out),
    .mispredict   (mispredict),
    .cdb0_valid   (cdb0_valid),
    .cdb0_preg    (cdb0_preg),
    .cdb0_rob     (cdb0_rob),
    .cdb1_valid   (cdb1_valid),
    .cdb1_preg    (cdb1_preg),
    .cdb1_rob     (cdb1_rob),
    .conflict_cnt (conflict_cnt)
  );

  typedef struct {
    logic        v0;
    logic [6:0]  p0;
    logic [4:0]  r0;
    logic        v1;
    logic [6:0]  p1;
    logic [4:0]  r1;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int n_tx  = 0;
  bit verbose = 1'b1;

  // reference model state
  int          m_rr  = 0;
  int          m_cnt = 0;
  logic [6:0]  m_p0 = '0, m_p1 = '0;
  logic [4:0]  m_r0 = '0, m_r1 = '0;

  // last applied stimulus and observed grants
  logic [2:0]       last_v = '0, last_g = '0, obs_ready = '0;
  logic [2:0][6:0]  last_p = '0;
  logic [2:0][4:0]  last_r = '0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, check grants, and
  // record what the next rising edge must broadcast.
  task automatic apply(input logic [2:0] v, input logic [2:0][6:0] p,
                       input logic [2:0][4:0] r, input logic mp);
    int   sel[$];
    logic [2:0] g;
    exp_t e;
    @(negedge clk);
    alu_valid_in = v[0]; alu_prd_in = p[0]; alu_rob_in = r[0];
    br_valid_in  = v[1]; br_prd_in  = p[1]; br_rob_in  = r[1];
    lsu_valid_in = v[2]; lsu_prd_in = p[2]; lsu_rob_in = r[2];
    mispredict   = mp;
    #1;
    g = '0;
    if (!mp) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_rr + k) % 3;
        if (v[idx] && sel.size() < 2) sel.push_back(idx);
      end
    end
    foreach (sel[i]) g[sel[i]] = 1'b1;
    obs_ready = {lsu_ready_out, br_ready_out, alu_ready_out};
    check("ready", int'(obs_ready), int'(g));

    e.v0 = (sel.size() > 0);
    e.v1 = (sel.size() > 1);
    if (e.v0) begin m_p0 = p[sel[0]]; m_r0 = r[sel[0]]; end
    if (e.v1) begin m_p1 = p[sel[1]]; m_r1 = r[sel[1]]; end
    e.p0 = m_p0; e.r0 = m_r0; e.p1 = m_p1; e.r1 = m_r1;
    if (!mp && v == 3'b111) begin
      m_rr = (m_rr + 2) % 3;
      if (PERF && m_cnt < 65535) m_cnt++;
    end
    e.cnt = 16'(m_cnt);
    exp_q.push_back(e);
    last_v = v; last_g = g; last_p = p; last_r = r;
  endtask

  // Random pattern honouring the hold rule for denied requesters.
  task automatic apply_random();
    logic [2:0]      v;
    logic [2:0][6:0] p;
    logic [2:0][4:0] r;
    logic            mp;
    for (int k = 0; k < 3; k++) begin
      if (last_v[k] && !last_g[k]) begin
        v[k] = 1'b1; p[k] = last_p[k]; r[k] = last_r[k];
      end else begin
        v[k] = ($urandom_range(0, 99) < 65);
        p[k] = ($urandom_range(0, 19) == 0) ? 7'd0 : 7'($urandom);
        r[k] = 5'($urandom);
      end
    end
    mp = ($urandom_range(0, 9) == 0);
    apply(v, p, r, mp);
  endtask

  task automatic model_reset();
    m_rr = 0; m_cnt = 0;
    m_p0 = '0; m_p1 = '0; m_r0 = '0; m_r1 = '0;
    last_v = '0; last_g = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ready"}, int'({lsu_ready_out, br_ready_out, alu_ready_out}), 0);
    check({tag, " cdb0_valid"}, int'(cdb0_valid), 0);
    check({tag, " cdb1_valid"}, int'(cdb1_valid), 0);
    check({tag, " cdb0_preg"}, int'(cdb0_preg), 0);
    check({tag, " cdb1_preg"}, int'(cdb1_preg), 0);
    check({tag, " cdb0_rob"}, int'(cdb0_rob), 0);
    check({tag, " cdb1_rob"}, int'(cdb1_rob), 0);
    check({tag, " conflict_cnt"}, int'(conflict_cnt), 0);
  endtask

  // Monitor: one expected broadcast per rising edge while the queue holds one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tx++;
        check("cdb0_valid", int'(cdb0_valid), int'(e.v0));
        check("cdb0_preg",  int'(cdb0_preg),  int'(e.p0));
        check("cdb0_rob",   int'(cdb0_rob),   int'(e.r0));
        check("cdb1_valid", int'(cdb1_valid), int'(e.v1));
        check("cdb1_preg",  int'(cdb1_preg),  int'(e.p1));
        check("cdb1_rob",   int'(cdb1_rob),   int'(e.r1));
        check("conflict_cnt", int'(conflict_cnt), int'(e.cnt));
        if (verbose)
          $display("tx %0d: cdb0 v=%0d preg=%0d rob=%0d | cdb1 v=%0d preg=%0d rob=%0d | cnt=%0d",
                   n_tx, cdb0_valid, cdb0_preg, cdb0_rob,
                   cdb1_valid, cdb1_preg, cdb1_rob, conflict_cnt);
      end
    end
  end

  initial begin
    logic [2:0][6:0] p;
    logic [2:0][4:0] r;
    int deny[3];
    int grants;

    // ---- power-on reset, with requests already pending ----
    reset = 1'b0; mispredict = 1'b0;
    alu_valid_in = 1'b1; br_valid_in = 1'b1; lsu_valid_in = 1'b1;
    alu_prd_in = 7'd1; br_prd_in = 7'd2; lsu_prd_in = 7'd3;
    alu_rob_in = 5'd1; br_rob_in = 5'd2; lsu_rob_in = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    alu_valid_in = 1'b0; br_valid_in = 1'b0; lsu_valid_in = 1'b0;
    #1 reset = 1'b1;

    // ---- single ALU request right after reset ----
    p = '{7'd0, 7'd0, 7'd5};
    r = '{5'd0, 5'd0, 5'd3};
    apply(3'b001, p, r, 1'b0);
    check("alu_only ready", int'(obs_ready), 1);

    // ---- all three held for six cycles ----
    p = '{7'd12, 7'd11, 7'd10};
    r = '{5'd22, 5'd21, 5'd20};
    deny = '{0, 0, 0};
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      apply(3'b111, p, r, 1'b0);
      if (c == 0) check("3way first grant", int'(obs_ready), 3'b011);
      if (c == 1) check("3way second grant", int'(obs_ready), 3'b101);
      for (int k = 0; k < 3; k++) begin
        if (!obs_ready[k]) deny[k]++;
        else grants++;
      end
    end
    apply(3'b000, p, r, 1'b0);
    for (int k = 0; k < 3; k++) check($sformatf("deny count %0d", k), deny[k], 2);
    check("3way grants", grants, 12);
    check("3way conflict_cnt", int'(conflict_cnt), PERF ? 6 : 0);

    // ---- mispredict with BR+LSU, then a 3-way to expose rr_ptr ----
    p = '{7'd33, 7'd32, 7'd31};
    r = '{5'd13, 5'd12, 5'd11};
    apply(3'b110, p, r, 1'b1);
    apply(3'b111, p, r, 1'b0);
    apply(3'b000, p, r, 1'b0);

    // ---- randomized traffic ----
    for (int c = 0; c < 250; c++) apply_random();

    // ---- reset asserted between edges with a broadcast pending ----
    p = '{7'd0, 7'd0, 7'd77};
    r = '{5'd0, 5'd0, 5'd17};
    apply(3'b001, p, r, 1'b0);
    @(posedge clk);
    #3;
    check("pre-reset cdb0_valid", int'(cdb0_valid), 1);
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    model_reset();
    alu_valid_in = 1'b0; br_valid_in = 1'b0; lsu_valid_in = 1'b0;
    mispredict = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;

    // first cycle after release must grant; rr back at ALU
    p = '{7'd42, 7'd41, 7'd40};
    r = '{5'd2, 5'd1, 5'd0};
    apply(3'b111, p, r, 1'b0);
    check("post-reset grant", int'(obs_ready), 3'b011);

    for (int c = 0; c < 100; c++) apply_random();

`ifdef WB_ARBITER_PERF_EN
    // ---- saturation of the conflict counter ----
    verbose = 1'b0;
    for (int c = 0; c < 65540; c++) apply(3'b111, p, r, 1'b0);
    apply(3'b000, p, r, 1'b0);
    check("conflict_cnt saturated", int'(conflict_cnt), 65535);
    verbose = 1'b1;
`endif

    // ---- drain ----
    apply(3'b000, p, r, 1'b0);
    @(posedge clk);
    #2;
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 alu_valid_in / br_valid_in / lsu_valid_in  input  1 each  FU result request.
REQ-004 alu_prd_in / br_prd_in / lsu_prd_in  input  7 each  destination physical register.
REQ-005 alu_rob_in / br_rob_in / lsu_rob_in  input  5 each  ROB index of completing instruction.
REQ-006 alu_ready_out / br_ready_out / lsu_ready_out  output  1 each  grant; the transfer occurs when valid and ready are both high.
REQ-007 mispredict  input  1  flush strobe from the ROB.
REQ-008 cdb0_valid / cdb1_valid  output  1 each  broadcast slot valid (drives preg1_valid/preg2_valid).
REQ-009 cdb0_preg / cdb1_preg  output  7 each  broadcast tag (drives preg1_rdy/preg2_rdy).
REQ-010 cdb0_rob / cdb1_rob  output  5 each  ROB completion tag.
REQ-011 conflict_cnt  output  16  performance counter (see Configuration).

Function
REQ-012 Requesters are indexed ALU=0, BR=1, LSU=2; the block shall hold a 2-bit round-robin pointer rr_ptr in {0,1,2}; the priority order is rr_ptr, (rr_ptr+1)%3, (rr_ptr+2)%3.
REQ-013 Grants shall be combinational from the current valids and rr_ptr: at most 2 grants per cycle, given to the first two valid requesters in priority order.
REQ-014 ready_out shall never be high for a requester whose valid is low.
REQ-015 The highest-priority granted request shall load cdb0 and the second shall load cdb1 on the next edge; latency is exactly 1 cycle from grant to broadcast.
REQ-016 A slot with no grant shall load valid=0, and its preg/rob fields shall hold their previous values.
REQ-017 With 3 requests, the denied requester ((rr_ptr+2)%3) shall become rr_ptr on the next edge; with 0-2 requests, rr_ptr shall be unchanged.
REQ-018 A denied requester must hold valid and payload stable; the block shall not buffer denied requests.
REQ-019 A single request shall always go to cdb0, with cdb1_valid=0.
REQ-020 prd=0 requests shall be arbitrated and broadcast like any other request (the ROB needs the completion).
REQ-021 While mispredict=1, all ready_out shall be 0, and cdb0_valid/cdb1_valid shall be 0 on the next edge.
REQ-022 rr_ptr shall not change during a mispredict cycle.
REQ-023 cdb outputs shall be driven directly from flops, with no combinational path from inputs.
REQ-024 rr_ptr=3 is illegal; if reached, it shall be treated as 0 for priority and shall load 0 on the next edge.

Reset
REQ-025 When reset=0, the block shall asynchronously force cdb0_valid=0, cdb1_valid=0, cdb*_preg=0, cdb*_rob=0, rr_ptr=0 and conflict_cnt=0.
REQ-026 ready_out shall be 0 while reset=0.
REQ-027 The first grant shall be possible in the first cycle after reset deasserts.
REQ-028 If reset is asserted mid-operation, in-flight broadcasts shall be discarded without being emitted.

Configuration
REQ-029 Macro WB_ARBITER_PERF_EN controls the performance counter.
REQ-030 With WB_ARBITER_PERF_EN defined, conflict_cnt shall increment by 1 on each non-mispredict cycle in which all 3 valids are high, and shall saturate at 16'hFFFF.
REQ-031 Without WB_ARBITER_PERF_EN, conflict_cnt shall be constant 0 with no counter flops; all other behaviour shall be identical.

Verification
REQ-032 After reset, ALU only (prd=7'd5, rob=5'd3) -> alu_ready=1 same cycle; next cycle cdb0_valid=1, cdb0_preg=5, cdb0_rob=3, cdb1_valid=0.
REQ-033 rr_ptr=0 with all 3 valid (ALU prd 10, BR prd 11, LSU prd 12) -> ALU/BR granted, LSU ready=0; next cycle cdb0_preg=10, cdb1_preg=11, rr_ptr=2. Holding all 3 valid then grants LSU (cdb0=12) and ALU (cdb1=10).
REQ-034 All 3 held valid for 6 cycles -> each requester is denied exactly twice; there are 12 broadcasts total; conflict_cnt=6 when WB_ARBITER_PERF_EN is defined, 0 when it is not.
REQ-035 mispredict=1 with BR+LSU valid -> all ready=0; next cycle both cdb valids=0; rr_ptr unchanged.
REQ-036 reset=0 asserted between edges while cdb0_valid=1 -> cdb0_valid drops immediately without waiting for clk; rr_ptr=0.
REQ-037 Counter saturation: force 70000 consecutive 3-way conflict cycles with WB_ARBITER_PERF_EN defined -> conflict_cnt=16'hFFFF and it holds at that value.
